// File: rtl/csr_hub.sv
// Avalon-MM CSR bank for the memory checker: parameter/result words plus a toggle
// start/done handshake into clk_mem_i. Optional DONE interrupt under CSR_HUB_IRQ_EN.
module csr_hub #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned PARAM_CNT  = 8,
    parameter int unsigned RESULT_CNT = 8,
    parameter int unsigned SYNC_STG   = 2
) (
    input  logic                         clk_sys_i,
    input  logic                         rst_sys_i,
    input  logic                         clk_mem_i,
    input  logic                         rst_mem_i,
    input  logic                         read_i,
    input  logic                         write_i,
    input  logic [ADDR_W-1:0]            address_i,
    input  logic [DATA_W-1:0]            writedata_i,
    output logic                         readdatavalid_o,
    output logic [DATA_W-1:0]            readdata_o,
    input  logic                         test_finished_i,
    input  logic [RESULT_CNT*DATA_W-1:0] test_result_i,
    output logic                         test_start_o,
    output logic [PARAM_CNT*DATA_W-1:0]  test_param_o,
    output logic                         irq_o
);

    localparam int unsigned PARAM_BASE  = 4;
    localparam int unsigned RESULT_BASE = PARAM_BASE + PARAM_CNT;
    localparam int unsigned MAP_WORDS   = RESULT_BASE + RESULT_CNT;
    localparam int unsigned LAST        = SYNC_STG - 1;

`ifdef CSR_HUB_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    generate
        if (MAP_WORDS > (2 ** ADDR_W)) begin : g_bad_map
            $error("csr_hub: register map does not fit in ADDR_W");
        end
        if (SYNC_STG < 2) begin : g_bad_sync
            $error("csr_hub: SYNC_STG must be >= 2");
        end
        if (DATA_W < 8) begin : g_bad_data
            $error("csr_hub: DATA_W must be >= 8");
        end
    endgenerate

    // ---------------- clk_mem_i domain ----------------
    logic [SYNC_STG-1:0] start_sync_q, start_sync_d;
    logic                ack_tgl_q, ack_tgl_d;
    logic                test_start_q, test_start_d;
    logic                done_tgl_q, done_tgl_d;

    // ---------------- clk_sys_i domain ----------------
    logic                                start_tgl_q, start_tgl_d;
    logic                                start_q, start_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;
    logic                                drop_q, drop_d;
    logic                                mask_q, mask_d;
    logic                                irq_q, irq_d;
    logic [SYNC_STG-1:0]                 ack_sync_q, ack_sync_d;
    logic [SYNC_STG-1:0]                 done_sync_q, done_sync_d;
    logic                                done_seen_q, done_seen_d;
    logic [PARAM_CNT-1:0][DATA_W-1:0]    param_q, param_d;
    logic [RESULT_CNT-1:0][DATA_W-1:0]   result_q, result_d;
    logic                                rd_vld_q, rd_vld_d;
    logic [ADDR_W-1:0]                   rd_addr_q, rd_addr_d;
    logic                                rdv_q, rdv_d;
    logic [DATA_W-1:0]                   rdata_q, rdata_d;
    logic                                capture;

    // Mem side: synchronise start toggle, pulse on its edge, echo it back, toggle on done.
    always_comb begin
        start_sync_d = {start_sync_q[SYNC_STG-2:0], start_tgl_q};
        ack_tgl_d    = start_sync_q[LAST];
        test_start_d = start_sync_q[LAST] ^ ack_tgl_q;
        done_tgl_d   = done_tgl_q ^ test_finished_i;
    end

    always_ff @(posedge clk_mem_i or posedge rst_mem_i) begin
        if (rst_mem_i) begin
            start_sync_q <= '0;
            ack_tgl_q    <= 1'b0;
            test_start_q <= 1'b0;
            done_tgl_q   <= 1'b0;
        end else begin
            start_sync_q <= start_sync_d;
            ack_tgl_q    <= ack_tgl_d;
            test_start_q <= test_start_d;
            done_tgl_q   <= done_tgl_d;
        end
    end

    // Sys side: register writes, handshake tracking, result capture and read pipeline.
    always_comb begin
        start_tgl_d = start_tgl_q;
        start_d     = start_q;
        busy_d      = busy_q;
        done_d      = done_q;
        drop_d      = drop_q;
        mask_d      = mask_q;
        param_d     = param_q;
        result_d    = result_q;
        ack_sync_d  = {ack_sync_q[SYNC_STG-2:0], ack_tgl_q};
        done_sync_d = {done_sync_q[SYNC_STG-2:0], done_tgl_q};
        done_seen_d = done_sync_q[LAST];
        capture     = (done_sync_q[LAST] ^ done_seen_q) & busy_q;
        rd_vld_d    = read_i;
        rd_addr_d   = address_i;
        rdv_d       = rd_vld_q;
        rdata_d     = '0;

        if (start_q && (ack_sync_q[LAST] == start_tgl_q)) begin
            start_d = 1'b0;
        end

        if (write_i) begin
            if ((address_i == ADDR_W'(0)) && writedata_i[0]) begin
                // Decode uses registered BUSY, so a start colliding with a capture is dropped.
                if (busy_q) begin
                    drop_d = 1'b1;
                end else begin
                    start_tgl_d = ~start_tgl_q;
                    start_d     = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            if (address_i == ADDR_W'(1)) begin
                if (writedata_i[1]) done_d = 1'b0;
                if (writedata_i[2]) drop_d = 1'b0;
            end
            if (IRQ_EN && (address_i == ADDR_W'(2))) begin
                mask_d = writedata_i[0];
            end
            for (int unsigned k = 0; k < PARAM_CNT; k++) begin
                if (!busy_q && (address_i == ADDR_W'(PARAM_BASE + k))) begin
                    param_d[k] = writedata_i;
                end
            end
        end

        // Applied after the W1C so a simultaneous done set wins.
        if (capture) begin
            result_d = test_result_i;
            busy_d   = 1'b0;
            done_d   = 1'b1;
        end

        irq_d = IRQ_EN & done_d & mask_d;

        case (rd_addr_q)
            ADDR_W'(0): rdata_d = DATA_W'(start_q);
            ADDR_W'(1): rdata_d = DATA_W'({drop_q, done_q, busy_q});
            ADDR_W'(2): rdata_d = DATA_W'(IRQ_EN & mask_q);
            default:    rdata_d = '0;
        endcase
        for (int unsigned k = 0; k < PARAM_CNT; k++) begin
            if (rd_addr_q == ADDR_W'(PARAM_BASE + k)) rdata_d = param_q[k];
        end
        for (int unsigned k = 0; k < RESULT_CNT; k++) begin
            if (rd_addr_q == ADDR_W'(RESULT_BASE + k)) rdata_d = result_q[k];
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            start_tgl_q <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            mask_q      <= 1'b0;
            irq_q       <= 1'b0;
            ack_sync_q  <= '0;
            done_sync_q <= '0;
            done_seen_q <= 1'b0;
            param_q     <= '0;
            result_q    <= '0;
            rd_vld_q    <= 1'b0;
            rd_addr_q   <= '0;
            rdv_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            start_tgl_q <= start_tgl_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
            mask_q      <= mask_d;
            irq_q       <= irq_d;
            ack_sync_q  <= ack_sync_d;
            done_sync_q <= done_sync_d;
            done_seen_q <= done_seen_d;
            param_q     <= param_d;
            result_q    <= result_d;
            rd_vld_q    <= rd_vld_d;
            rd_addr_q   <= rd_addr_d;
            rdv_q       <= rdv_d;
            rdata_q     <= rdata_d;
        end
    end

    assign readdatavalid_o = rdv_q;
    assign readdata_o      = rdata_q;
    assign test_start_o    = test_start_q;
    assign test_param_o    = param_q;
    assign irq_o           = irq_q;

endmodule

// File: tb/tb_csr_hub.sv
// Directed self-checking bench for csr_hub (default 32-bit, 8+8 word configuration).
module tb_csr_hub;

    logic         clk_sys_i = 1'b0;
    logic         clk_mem_i = 1'b0;
    logic         rst_sys_i = 1'b1;
    logic         rst_mem_i = 1'b1;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic [5:0]   address_i = '0;
    logic [31:0]  writedata_i = '0;
    logic         readdatavalid_o;
    logic [31:0]  readdata_o;
    logic         test_finished_i = 1'b0;
    logic [255:0] test_result_i = '0;
    logic         test_start_o;
    logic [255:0] test_param_o;
    logic         irq_o;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    csr_hub dut (
        .clk_sys_i       (clk_sys_i),
        .rst_sys_i       (rst_sys_i),
        .clk_mem_i       (clk_mem_i),
        .rst_mem_i       (rst_mem_i),
        .read_i          (read_i),
        .write_i         (write_i),
        .address_i       (address_i),
        .writedata_i     (writedata_i),
        .readdatavalid_o (readdatavalid_o),
        .readdata_o      (readdata_o),
        .test_finished_i (test_finished_i),
        .test_result_i   (test_result_i),
        .test_start_o    (test_start_o),
        .test_param_o    (test_param_o),
        .irq_o           (irq_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;
    always #7 clk_mem_i = ~clk_mem_i;

    // Each sampled high cycle counts, so a wide pulse shows up as extra starts.
    always @(negedge clk_mem_i) begin
        if (!rst_mem_i && test_start_o) start_cnt = start_cnt + 1;
    end

    task automatic sys_wait(input int n);
        repeat (n) @(posedge clk_sys_i);
    endtask

    task automatic csr_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk_sys_i);
        write_i = 1'b1; address_i = a; writedata_i = d;
        @(negedge clk_sys_i);
        write_i = 1'b0;
    endtask

    task automatic csr_read(input logic [5:0] a, output logic [31:0] d, output bit lat_ok);
        @(negedge clk_sys_i);
        read_i = 1'b1; address_i = a;
        @(posedge clk_sys_i); #1;
        lat_ok = (readdatavalid_o === 1'b0);
        read_i = 1'b0;
        @(posedge clk_sys_i); #1;
        lat_ok = lat_ok && (readdatavalid_o === 1'b1);
        d = readdata_o;
    endtask

    task automatic pulse_finished();
        @(negedge clk_mem_i); test_finished_i = 1'b1;
        @(negedge clk_mem_i); test_finished_i = 1'b0;
    endtask

    task automatic set_results(input logic [31:0] base);
        for (int k = 0; k < 8; k++) test_result_i[k*32 +: 32] = base + 32'(k);
    endtask

    task automatic test_reset();
        logic [31:0] d; bit ok;
        rst_sys_i = 1'b1; rst_mem_i = 1'b1;
        sys_wait(3);
        @(negedge clk_sys_i); #1;
        checks++; if (readdatavalid_o !== 1'b0) begin errors++; $display("FAIL reset_rdv: got %b want 0", readdatavalid_o); end
        checks++; if (readdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", readdata_o); end
        checks++; if (test_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", test_start_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq_o); end
        checks++; if (test_param_o !== 256'h0) begin errors++; $display("FAIL reset_param: got %h want 0", test_param_o); end
        rst_sys_i = 1'b0; rst_mem_i = 1'b0;
        sys_wait(2);
        csr_read(6'd1, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", d); end
        csr_read(6'd0, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", d); end
    endtask

    task automatic test_params();
        logic [31:0] d; bit ok;
        for (int k = 0; k < 8; k++) csr_write(6'(4 + k), 32'hA0 + 32'(k));
        for (int k = 0; k < 8; k++) begin
            csr_read(6'(4 + k), d, ok);
            checks++; if (d !== 32'hA0 + 32'(k)) begin errors++; $display("FAIL param_rd%0d: got %h want %h", k, d, 32'hA0 + 32'(k)); end
            checks++; if (!ok) begin errors++; $display("FAIL param_lat%0d: valid not exactly 2 cycles after read", k); end
        end
        checks++; if (test_param_o[3*32 +: 32] !== 32'hA3) begin errors++; $display("FAIL param_out3: got %h want a3", test_param_o[3*32 +: 32]); end
        csr_read(6'd3, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reserved_rd: got %h want 0", d); end
        csr_write(6'd40, 32'h5555);
        csr_read(6'd40, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got %h want 0", d); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys_i);
            if (i >= 2 && i <= 4) begin
                checks++; if (readdatavalid_o !== 1'b1 || readdata_o !== 32'hA0 + 32'(i - 2)) begin
                    errors++; $display("FAIL b2b_rd%0d: got v=%b d=%h want v=1 d=%h", i - 2, readdatavalid_o, readdata_o, 32'hA0 + 32'(i - 2));
                end
            end
            if (i == 5) begin
                checks++; if (readdatavalid_o !== 1'b0) begin errors++; $display("FAIL b2b_tail: got v=%b want 0", readdatavalid_o); end
            end
            if (i < 3) begin read_i = 1'b1; address_i = 6'(4 + i); end
            else read_i = 1'b0;
        end
    endtask

    task automatic test_start();
        logic [31:0] d; bit ok; int base;
        base = start_cnt;
        csr_write(6'd0, 32'h1);
        csr_read(6'd0, d, ok);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL start_pending: got %h want 1", d); end
        sys_wait(20);
        checks++; if (start_cnt - base !== 1) begin errors++; $display("FAIL start_pulses: got %0d want 1", start_cnt - base); end
        csr_read(6'd0, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL start_acked: got %h want 0", d); end
        csr_read(6'd1, d, ok);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL start_status: got %h want 1", d); end
    endtask

    task automatic test_done();
        logic [31:0] d; bit ok;
        set_results(32'h100);
        pulse_finished();
        sys_wait(20);
        csr_read(6'd1, d, ok);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL done_status: got %h want 2", d); end
        for (int k = 0; k < 8; k++) begin
            csr_read(6'(12 + k), d, ok);
            checks++; if (d !== 32'h100 + 32'(k)) begin errors++; $display("FAIL result_rd%0d: got %h want %h", k, d, 32'h100 + 32'(k)); end
        end
        csr_write(6'd1, 32'h2);
        csr_read(6'd1, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL done_w1c: got %h want 0", d); end
    endtask

    task automatic test_drop();
        logic [31:0] d; bit ok; int base;
        base = start_cnt;
        csr_write(6'd0, 32'h1);
        sys_wait(20);
        csr_write(6'd0, 32'h1);
        csr_write(6'd4, 32'hDEAD);
        sys_wait(20);
        checks++; if (start_cnt - base !== 1) begin errors++; $display("FAIL drop_pulses: got %0d want 1", start_cnt - base); end
        csr_read(6'd1, d, ok);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL drop_status: got %h want 5", d); end
        csr_read(6'd4, d, ok);
        checks++; if (d !== 32'hA0) begin errors++; $display("FAIL drop_param: got %h want a0", d); end
        checks++; if (test_param_o[31:0] !== 32'hA0) begin errors++; $display("FAIL drop_param_out: got %h want a0", test_param_o[31:0]); end
        pulse_finished();
        sys_wait(20);
        csr_read(6'd1, d, ok);
        checks++; if (d !== 32'h6) begin errors++; $display("FAIL drop_done: got %h want 6", d); end
        csr_write(6'd1, 32'h6);
        csr_read(6'd1, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL drop_clear: got %h want 0", d); end
    endtask

    task automatic test_done_idle();
        logic [31:0] d; bit ok;
        set_results(32'h200);
        pulse_finished();
        sys_wait(20);
        csr_read(6'd1, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL idle_status: got %h want 0", d); end
        csr_read(6'd12, d, ok);
        checks++; if (d !== 32'h100) begin errors++; $display("FAIL idle_capture: got %h want 100", d); end
    endtask

`ifdef CSR_HUB_IRQ_EN
    task automatic test_irq();
        logic [31:0] d; bit ok;
        csr_write(6'd2, 32'h1);
        csr_read(6'd2, d, ok);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL irq_mask_rd: got %h want 1", d); end
        csr_write(6'd0, 32'h1);
        sys_wait(20);
        pulse_finished();
        sys_wait(20);
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq_o); end
        @(negedge clk_sys_i);
        write_i = 1'b1; address_i = 6'd1; writedata_i = 32'h2;
        @(posedge clk_sys_i); #1;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq_o); end
        @(negedge clk_sys_i);
        write_i = 1'b0;
    endtask
`else
    task automatic test_irq();
        logic [31:0] d; bit ok;
        csr_write(6'd2, 32'h1);
        csr_read(6'd2, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_mask_off: got %h want 0", d); end
        csr_write(6'd0, 32'h1);
        sys_wait(20);
        pulse_finished();
        sys_wait(20);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_off: got %b want 0", irq_o); end
        csr_write(6'd1, 32'h2);
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] d; bit ok; int base;
        csr_write(6'd0, 32'h1);
        sys_wait(1);
        @(negedge clk_sys_i);
        rst_sys_i = 1'b1; rst_mem_i = 1'b1;
        sys_wait(3);
        @(negedge clk_sys_i);
        rst_sys_i = 1'b0; rst_mem_i = 1'b0;
        base = start_cnt;
        sys_wait(30);
        checks++; if (start_cnt - base !== 0) begin errors++; $display("FAIL rst_mid_start: got %0d pulses want 0", start_cnt - base); end
        checks++; if (test_param_o !== 256'h0) begin errors++; $display("FAIL rst_mid_param: got %h want 0", test_param_o); end
        csr_read(6'd0, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_ctrl: got %h want 0", d); end
        csr_read(6'd1, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_status: got %h want 0", d); end
        csr_read(6'd4, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_param_rd: got %h want 0", d); end
        csr_read(6'd12, d, ok);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_result: got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_params();
        test_back_to_back();
        test_start();
        test_done();
        test_drop();
        test_done_idle();
        test_irq();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
